// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, fetched-instruction register and
// next-PC selection (JumpReg > Jump > taken Branch > sequential) with a
// sticky HALT state for misaligned register jumps and out-of-range PCs.
module instr_fetch #(
  parameter logic [29:0] RESET_PC  = 30'h0,
  parameter int          MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [25:0] TargetInstr,
  input  logic [15:0] Imm,
  input  logic [31:0] RegAddr,
  input  logic [31:0] InstrIn,
  output logic [29:0] Addr,
  output logic [31:0] InstrOut,
  output logic [29:0] PCPlus1,
  output logic        Valid,
  output logic        Fault
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // One bit wider than a PC so the range limit itself is representable.
  localparam logic [30:0] MEM_LIMIT = 31'(MEM_WORDS);

  state_e      state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [29:0] pcp1_q, pcp1_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [29:0] pc_inc_s;
  logic [29:0] npc_s;
  logic        take_jr_s;
  logic        take_j_s;
  logic        take_br_s;
  logic        redirect_s;
  logic        misalign_s;
  logic        out_of_range_s;

  // Next-PC selection; redirects only count when the held instruction is real.
  always_comb begin
    pc_inc_s       = pc_q + 30'd1;
    take_jr_s      = valid_q & JumpReg;
    take_j_s       = valid_q & Jump;
    take_br_s      = valid_q & Branch & Zero;
    redirect_s     = take_jr_s | take_j_s | take_br_s;
    misalign_s     = take_jr_s & (RegAddr[1:0] != 2'b00);
    npc_s          = pc_inc_s;
    if (take_jr_s) begin
      npc_s = RegAddr[31:2];
    end else if (take_j_s) begin
      npc_s = {pcp1_q[29:26], TargetInstr};
    end else if (take_br_s) begin
      npc_s = pcp1_q + {{14{Imm[15]}}, Imm};
    end else begin
      npc_s = pc_inc_s;
    end
    out_of_range_s = ({1'b0, npc_s} >= MEM_LIMIT);
  end

  // Fetch FSM next-state: advance, squash on redirect, or halt on a fault.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp1_d  = pcp1_q;
    valid_d = valid_q;
    fault_d = fault_q;
    case (state_q)
      ST_RUN: begin
        if (stall) begin
          state_d = state_q;
        end else if (misalign_s || out_of_range_s) begin
          // PC, InstrOut and PCPlus1 are frozen at the faulting point.
          state_d = ST_HALT;
          valid_d = 1'b0;
          fault_d = 1'b1;
        end else begin
          instr_d = InstrIn;
          pcp1_d  = pc_inc_s;
          pc_d    = npc_s;
          valid_d = ~redirect_s;
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: begin
        state_d = ST_HALT;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      pcp1_q  <= 30'h0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp1_q  <= pcp1_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign Addr     = pc_q;
  assign InstrOut = instr_q;
  assign PCPlus1  = pcp1_q;
  assign Valid    = valid_q;
  assign Fault    = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected (InstrOut,
// PCPlus1) pairs, a negedge monitor pops one whenever Valid is high.
module tb_instr_fetch;

  typedef struct packed {
    logic [31:0] instr;
    logic [29:0] pcp1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, Jump, JumpReg, Branch, Zero;
  logic [25:0] TargetInstr;
  logic [15:0] Imm;
  logic [31:0] RegAddr;
  logic [31:0] InstrIn;
  logic [29:0] Addr;
  logic [31:0] InstrOut;
  logic [29:0] PCPlus1;
  logic        Valid;
  logic        Fault;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return 32'h1000_0000 + {2'b00, a};
  endfunction

  assign InstrIn = mem_word(Addr);

  instr_fetch #(.RESET_PC(30'h0), .MEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .Jump(Jump), .JumpReg(JumpReg),
    .Branch(Branch), .Zero(Zero), .TargetInstr(TargetInstr), .Imm(Imm),
    .RegAddr(RegAddr), .InstrIn(InstrIn), .Addr(Addr), .InstrOut(InstrOut),
    .PCPlus1(PCPlus1), .Valid(Valid), .Fault(Fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [29:0] a);
    exp_t e;
    e.instr = mem_word(a);
    e.pcp1  = a + 30'd1;
    exp_q.push_back(e);
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    Jump = 1'b0; JumpReg = 1'b0; Branch = 1'b0; Zero = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  {2'b00, Addr},    32'h0);
    chk({tag, "_instr"}, InstrOut,         32'h0);
    chk({tag, "_pcp1"},  {2'b00, PCPlus1}, 32'h0);
    chk({tag, "_valid"}, {31'h0, Valid},   32'h0);
    chk({tag, "_fault"}, {31'h0, Fault},   32'h0);
  endtask

  // Monitor: every presented valid instruction must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && Valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got instr %h pcp1 %h expected nothing", InstrOut, PCPlus1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_instr", InstrOut, e.instr);
        chk("sb_pcp1", {2'b00, PCPlus1}, {2'b00, e.pcp1});
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; clear_redirects();
    TargetInstr = 26'h0; Imm = 16'h0; RegAddr = 32'h0;
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch of words 0..4.
    for (int n = 0; n < 5; n++) begin
      push_exp(30'(n));
      clk_edge();
      if (n == 3) chk("seq_addr4", {2'b00, Addr}, 32'd4);
    end
    chk("seq_valid", {31'h0, Valid}, 32'd1);

    // Taken branch back by 3 from PCPlus1=5.
    Branch = 1'b1; Zero = 1'b1; Imm = 16'hFFFD;
    clk_edge();
    chk("br_addr", {2'b00, Addr}, 32'd2);
    chk("br_squash", {31'h0, Valid}, 32'd0);
    clear_redirects();
    push_exp(30'd2);
    clk_edge();
    chk("br_after_addr", {2'b00, Addr}, 32'd3);

    // Branch without Zero is sequential.
    Branch = 1'b1; Zero = 1'b0; Imm = 16'h0010;
    push_exp(30'd3);
    clk_edge();
    chk("br_nt_addr", {2'b00, Addr}, 32'd4);
    clear_redirects();

    // JumpReg and Jump together.
    JumpReg = 1'b1; RegAddr = 32'h40; Jump = 1'b1; TargetInstr = 26'h10;
    clk_edge();
    chk("prio_addr", {2'b00, Addr}, 32'h10);
    chk("prio_valid", {31'h0, Valid}, 32'd0);
    clear_redirects();
    push_exp(30'h10);
    clk_edge();

    // Stall with conflicting redirects pending: everything holds.
    stall = 1'b1; JumpReg = 1'b1; RegAddr = 32'h80; Jump = 1'b1; TargetInstr = 26'h30;
    for (int k = 0; k < 2; k++) begin
      push_exp(30'h10);
      clk_edge();
      chk("stall_addr", {2'b00, Addr}, 32'h11);
      chk("stall_instr", InstrOut, mem_word(30'h10));
      chk("stall_valid", {31'h0, Valid}, 32'd1);
    end
    stall = 1'b0;
    clk_edge();
    chk("jr_wins", {2'b00, Addr}, 32'h20);
    // Redirect while Valid=0 is ignored.
    JumpReg = 1'b0;
    push_exp(30'h20);
    clk_edge();
    chk("ign_invalid", {2'b00, Addr}, 32'h21);
    clk_edge();
    chk("jump_addr", {2'b00, Addr}, 32'h30);
    clear_redirects();
    push_exp(30'h30);
    clk_edge();

    // Async reset during a stall, between edges.
    @(negedge clk);
    #1 stall = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0;
    push_exp(30'd0);
    clk_edge();
    chk("arst_fetch0", {2'b00, Addr}, 32'd1);

    // Misaligned JumpReg halts.
    JumpReg = 1'b1; RegAddr = 32'h42;
    clk_edge();
    chk("mis_fault", {31'h0, Fault}, 32'd1);
    chk("mis_valid", {31'h0, Valid}, 32'd0);
    chk("mis_instr", InstrOut, mem_word(30'd0));
    JumpReg = 1'b0; Jump = 1'b1; TargetInstr = 26'h5;
    for (int k = 0; k < 5; k++) begin
      clk_edge();
      chk("halt_addr", {2'b00, Addr}, 32'd1);
      chk("halt_fault", {31'h0, Fault}, 32'd1);
    end
    clear_redirects();

    // Reset clears HALT.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("halt_rst_fault", {31'h0, Fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Range fault: jump near the top, then fetch sequentially up to 1023.
    push_exp(30'd0);
    clk_edge();
    JumpReg = 1'b1; RegAddr = 32'hFF0;
    clk_edge();
    chk("rng_jr_addr", {2'b00, Addr}, 32'd1020);
    clear_redirects();
    for (int n = 1020; n < 1023; n++) begin
      push_exp(30'(n));
      clk_edge();
    end
    chk("rng_addr1023", {2'b00, Addr}, 32'd1023);
    chk("rng_nofault", {31'h0, Fault}, 32'd0);
    clk_edge();
    chk("rng_fault", {31'h0, Fault}, 32'd1);
    chk("rng_valid", {31'h0, Valid}, 32'd0);
    chk("rng_addr_hold", {2'b00, Addr}, 32'd1023);
    chk("rng_pcp1_hold", {2'b00, PCPlus1}, 32'd1023);

    @(negedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 30'h0, word address loaded into PC on reset.
REQ-002 Parameter MEM_WORDS, default 1024, number of valid instruction-memory words; a PC at or above this value is out of range.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hold request from downstream; 1 freezes all fetch state.
REQ-006 Jump  input  1  redirect to pseudo-direct target for the instruction held in InstrOut.
REQ-007 JumpReg  input  1  redirect to register target.
REQ-008 Branch  input  1  conditional branch for the instruction held in InstrOut.
REQ-009 Zero  input  1  branch condition; the branch is taken when Branch and Zero are both 1.
REQ-010 TargetInstr  input  26  jump target field.
REQ-011 Imm  input  16  signed branch offset, in words.
REQ-012 RegAddr  input  32  byte address for JumpReg.
REQ-013 InstrIn  input  32  instruction word from instruction memory; combinational on Addr.
REQ-014 Addr  output  30  word address to instruction memory; equals PC combinationally.
REQ-015 InstrOut  output  32  registered fetched instruction.
REQ-016 PCPlus1  output  30  registered word address of InstrOut plus 1.
REQ-017 Valid  output  1  1 when InstrOut holds a non-squashed instruction.
REQ-018 Fault  output  1  sticky fetch fault; asserted in HALT.

Function
REQ-019 States: RUN and HALT only; all updates below apply in RUN.
REQ-020 Update when stall=0: InstrOut<=InstrIn; PCPlus1<=PC+1 (mod 2^30); PC<=next PC.
REQ-021 Update when stall=1: PC, InstrOut, PCPlus1, Valid and state all hold; redirect inputs are ignored that cycle.
REQ-022 Next-PC priority, highest first:
- JumpReg: RegAddr[31:2].
- Jump: {PCPlus1[29:26], TargetInstr}.
- Branch&&Zero: PCPlus1 + sign_extend(Imm) to 30 bits, mod 2^30.
- Otherwise: PC+1.
REQ-023 Redirect means any of JumpReg, Jump or Branch&&Zero with stall=0; on a redirect Valid<=0, squashing the wrong-path word captured that edge.
REQ-024 With stall=0 and no redirect, Valid<=1.
REQ-025 Redirect inputs take effect only when Valid=1; when Valid=0 they are ignored and the sequential PC is used.
REQ-026 Branch=1 with Zero=0 is not a redirect.
REQ-027 PC+1 wraps from 30'h3FFFFFFF to 0 arithmetically; that PC is then range-checked per REQ-030.
REQ-028 Latency: an instruction at address A appears on InstrOut with Valid=1 one edge after Addr=A with stall=0.
REQ-029 Fault, misaligned: an accepted JumpReg with RegAddr[1:0]!=0 moves the state to HALT.
REQ-030 Fault, range: a computed next PC >= MEM_WORDS moves the state to HALT.
REQ-031 On entering HALT: Fault<=1, Valid<=0, PC is not updated, InstrOut and PCPlus1 hold.
REQ-032 HALT is left only by reset; stall and redirect inputs have no effect in HALT.

Reset
REQ-033 Reset is asynchronous and active-low: rst_n=0 immediately sets PC=RESET_PC, InstrOut=0, PCPlus1=0, Valid=0, Fault=0, state RUN, regardless of clk or stall.
REQ-034 Reset asserted mid-operation (including during a stall or in HALT) discards all in-flight state.
REQ-035 After rst_n deasserts, the first rising edge fetches RESET_PC.

Verification
REQ-036 Sequential fetch: release reset, memory word n = 32'h1000_0000+n, stall=0 for 4 edges -> InstrOut 10000000..10000003, PCPlus1 1..4, Valid=1 from edge 1, Addr=4.
REQ-037 Taken branch: InstrOut valid with PCPlus1=5, Branch=Zero=1, Imm=16'hFFFD -> next Addr=2 and Valid=0; following edge InstrOut=mem[2], Valid=1.
REQ-038 Priority and stall:
- JumpReg=1, RegAddr=32'h40, Jump=1, TargetInstr=26'h10 together -> Addr=16'h10.
- Repeat with stall=1 -> Addr, InstrOut and Valid unchanged.
REQ-039 Faults:
- JumpReg with RegAddr=32'h42 -> Fault=1, Valid=0, Addr frozen for 5 further edges.
- Sequential fetch reaching PC=1023 -> next edge Fault=1.
REQ-040 Async reset: pull rst_n low between edges during a stall -> outputs reach reset values before the next edge; first edge after release fetches word 0.
